// File: rtl/led_cmd_pkg.sv
// Shared definitions for the LED command decoder: ASCII byte values,
// FSM state encoding, op encoding and small byte-classification helpers.
package led_cmd_pkg;

  // ASCII bytes recognised in a command frame and used for acknowledges
  localparam logic [7:0] CH_L_UP = 8'h4C;  // 'L'
  localparam logic [7:0] CH_L_LO = 8'h6C;  // 'l'
  localparam logic [7:0] CH_0    = 8'h30;  // '0'
  localparam logic [7:0] CH_1    = 8'h31;  // '1'
  localparam logic [7:0] CH_2    = 8'h32;  // '2'
  localparam logic [7:0] CH_3    = 8'h33;  // '3'
  localparam logic [7:0] CH_T_UP = 8'h54;  // 'T'
  localparam logic [7:0] CH_T_LO = 8'h74;  // 't'
  localparam logic [7:0] CH_B_UP = 8'h42;  // 'B'
  localparam logic [7:0] CH_B_LO = 8'h62;  // 'b'
  localparam logic [7:0] CH_CR   = 8'h0D;
  localparam logic [7:0] CH_LF   = 8'h0A;
  localparam logic [7:0] CH_K    = 8'h4B;  // 'K' acknowledge
  localparam logic [7:0] CH_E    = 8'h45;  // 'E' error response

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GOT_L,
    ST_GOT_IDX,
    ST_GOT_OP,
    ST_RESP
  } state_t;

  typedef enum logic [1:0] {
    OP_OFF,
    OP_ON,
    OP_TGL,
    OP_BLK
  } op_t;

  // Result of decoding an op byte: ok flags a legal op character
  typedef struct packed {
    logic ok;
    op_t  op;
  } op_dec_t;

  function automatic logic is_start(input logic [7:0] b);
    return (b == CH_L_UP) || (b == CH_L_LO);
  endfunction

  function automatic logic is_idx(input logic [7:0] b);
    logic r;
    case (b)
      CH_0, CH_1, CH_2, CH_3: r = 1'b1;
      default:                r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_term(input logic [7:0] b);
    return (b == CH_CR) || (b == CH_LF);
  endfunction

  function automatic op_dec_t decode_op(input logic [7:0] b);
    op_dec_t r;
    r = '{ok: 1'b1, op: OP_OFF};
    case (b)
      CH_0:             r.op = OP_OFF;
      CH_1:             r.op = OP_ON;
      CH_T_UP, CH_T_LO: r.op = OP_TGL;
      CH_B_UP, CH_B_LO: r.op = OP_BLK;
      default:          r.ok = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/led_cmd_decoder_blink_gen.sv
// Free-running blink source: a prescaler counting 0..BLINK_HALF-1 and a
// phase flop that flips at every prescaler wrap. Commands never reset it.
module blink_gen #(
  parameter int BLINK_HALF = 250000
) (
  input  logic clk,
  input  logic n_reset,
  output logic blink_phase
);

  localparam int               CNT_W    = (BLINK_HALF > 2) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_HALF - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic             wrap;

  // Next-state for prescaler and phase; phase flips on the wrap cycle
  always_comb begin
    wrap    = (cnt_q == CNT_LAST);
    cnt_d   = wrap ? '0 : cnt_q + CNT_W'(1);
    phase_d = phase_q ^ wrap;
  end

  // Prescaler and phase registers
  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge values computed in always_comb.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign blink_phase = phase_q;

endmodule

// File: rtl/led_cmd_decoder.sv
// ASCII LED command parser: consumes "L<idx><op><CR|LF>" frames from the
// UART receiver, maintains the 4-bit LED enable vector (on/off/toggle/blink)
// and returns a one-byte 'K'/'E' acknowledge over a valid/ready handshake.
module led_cmd_decoder
  import led_cmd_pkg::*;
#(
  parameter int BLINK_HALF  = 250000,
  parameter int TIMEOUT_CYC = 10000
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [3:0] en,
  output logic       cmd_err
);

  localparam int               GAP_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYC - 1);

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  op_t              op_q, op_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [3:0]       static_en_q, static_en_d;
  logic [3:0]       blink_mask_q, blink_mask_d;
  logic [3:0]       en_q, en_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic             cmd_err_q, cmd_err_d;

  logic             blink_phase;
  logic             in_frame;
  logic             timeout;
  logic             frame_err;
  op_dec_t          op_dec;

  blink_gen #(
    .BLINK_HALF (BLINK_HALF)
  ) u_blink_gen (
    .clk         (clk),
    .n_reset     (n_reset),
    .blink_phase (blink_phase)
  );

  // Frame parser, gap timer, op application and LED output mux
  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    op_d         = op_q;
    static_en_d  = static_en_q;
    blink_mask_d = blink_mask_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    cmd_err_d    = 1'b0;
    frame_err    = 1'b0;
    op_dec       = decode_op(rx_data);

    // Gap timer only runs between bytes of a partially received frame
    in_frame = (state_q == ST_GOT_L) || (state_q == ST_GOT_IDX) ||
               (state_q == ST_GOT_OP);
    if (!in_frame || rx_valid) gap_d = '0;
    else                       gap_d = gap_q + GAP_W'(1);
    // A byte arriving on the timeout cycle wins over the timeout
    timeout = in_frame && !rx_valid && (gap_q == GAP_LAST);

    case (state_q)
      ST_IDLE: begin
        // Anything but a start byte is ignored, which absorbs stray CR/LF
        if (rx_valid && is_start(rx_data)) state_d = ST_GOT_L;
      end
      ST_GOT_L: begin
        if (rx_valid) begin
          if (is_idx(rx_data)) begin
            idx_d   = rx_data[1:0];
            state_d = ST_GOT_IDX;
          end else begin
            frame_err = 1'b1;
          end
        end else if (timeout) begin
          frame_err = 1'b1;
        end
      end
      ST_GOT_IDX: begin
        if (rx_valid) begin
          if (op_dec.ok) begin
            op_d    = op_dec.op;
            state_d = ST_GOT_OP;
          end else begin
            frame_err = 1'b1;
          end
        end else if (timeout) begin
          frame_err = 1'b1;
        end
      end
      ST_GOT_OP: begin
        if (rx_valid) begin
          if (is_term(rx_data)) begin
            case (op_q)
              OP_OFF: begin
                static_en_d[idx_q]  = 1'b0;
                blink_mask_d[idx_q] = 1'b0;
              end
              OP_ON: begin
                static_en_d[idx_q]  = 1'b1;
                blink_mask_d[idx_q] = 1'b0;
              end
              OP_TGL: begin
                // Toggle what is actually lit, blink phase included
                static_en_d[idx_q]  = ~en_q[idx_q];
                blink_mask_d[idx_q] = 1'b0;
              end
              default: blink_mask_d[idx_q] = 1'b1;
            endcase
            tx_data_d  = CH_K;
            tx_valid_d = 1'b1;
            state_d    = ST_RESP;
          end else begin
            frame_err = 1'b1;
          end
        end else if (timeout) begin
          frame_err = 1'b1;
        end
      end
      ST_RESP: begin
        // Bytes arriving while the acknowledge is pending are dropped
        if (rx_valid) cmd_err_d = 1'b1;
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (frame_err) begin
      tx_data_d  = CH_E;
      tx_valid_d = 1'b1;
      cmd_err_d  = 1'b1;
      state_d    = ST_RESP;
    end

    for (int i = 0; i < 4; i++) begin
      en_d[i] = blink_mask_q[i] ? blink_phase : static_en_q[i];
    end
  end

  // All decoder state, including the registered outputs
  // NOTE: every flop here is a control or output register, so all of them
  // take the asynchronous reset; nothing here is a memory array.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= 2'd0;
      op_q         <= OP_OFF;
      gap_q        <= '0;
      static_en_q  <= 4'b0000;
      blink_mask_q <= 4'b0000;
      en_q         <= 4'b0000;
      tx_data_q    <= 8'h00;
      tx_valid_q   <= 1'b0;
      cmd_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      op_q         <= op_d;
      gap_q        <= gap_d;
      static_en_q  <= static_en_d;
      blink_mask_q <= blink_mask_d;
      en_q         <= en_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      cmd_err_q    <= cmd_err_d;
    end
  end

  assign en       = en_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign cmd_err  = cmd_err_q;

endmodule

// File: tb/tb_led_cmd_decoder.sv
// Self-checking bench for led_cmd_decoder with BLINK_HALF=8, TIMEOUT_CYC=20.
// Expected acknowledge bytes are queued when a frame is driven and compared
// when the handshake completes; LED state is tracked by a small model.
module tb_led_cmd_decoder;

  logic       clk = 1'b0;
  logic       n_reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [3:0] en;
  logic       cmd_err;

  int         total = 0;
  int         bad   = 0;
  int         err_seen = 0;
  int         exp_err  = 0;
  logic [7:0] sb[$];
  logic [3:0] exp_en;

  always #5 clk = ~clk;

  led_cmd_decoder #(
    .BLINK_HALF  (8),
    .TIMEOUT_CYC (20)
  ) dut (
    .clk      (clk),
    .n_reset  (n_reset),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .en       (en),
    .cmd_err  (cmd_err)
  );

  // Count every cycle cmd_err is seen high (a stretched pulse over-counts)
  always @(negedge clk) if (cmd_err === 1'b1) err_seen++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=stalled exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle rx strobe; returns at the negedge after the consuming edge
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  // Full well-formed frame; queues 'K' and updates the LED model
  task automatic frame(input logic [7:0] idx_ch, input logic [7:0] op_ch);
    int i;
    i = int'(idx_ch) - 48;
    send("L");
    send(idx_ch);
    send(op_ch);
    send(8'h0D);
    sb.push_back(8'h4B);
    case (op_ch)
      "0":      exp_en[i] = 1'b0;
      "1":      exp_en[i] = 1'b1;
      "T", "t": exp_en[i] = ~exp_en[i];
      default:  ;
    endcase
  endtask

  // Wait (bounded) for tx_valid, compare against the scoreboard, handshake
  task automatic ack(input string tag);
    int waited;
    logic [7:0] exp_b;
    waited = 0;
    while (tx_valid !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_valid"}, tx_valid, 1'b1);
    if (tx_valid === 1'b1) begin
      check({tag, "_sb_depth"}, sb.size(), 1);
      exp_b = (sb.size() > 0) ? sb.pop_front() : 8'h00;
      check({tag, "_data"}, tx_data, exp_b);
      tx_ready = 1'b1;
      @(negedge clk);
      tx_ready = 1'b0;
      check({tag, "_drop"}, tx_valid, 1'b0);
    end
  endtask

  initial begin
    int   edges[$];
    logic prev;

    n_reset  = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    exp_en   = 4'b0000;

    // Reset values
    idle(2);
    check("rst_en", en, 4'b0000);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_cmd_err", cmd_err, 1'b0);
    n_reset = 1'b1;
    idle(2);

    // "L11\r" with bytes 3 cycles apart, latency and held acknowledge
    send("L"); idle(2);
    send("1"); idle(2);
    send("1"); idle(2);
    send(8'h0D);
    sb.push_back(8'h4B);
    exp_en = 4'b0010;
    check("t1_valid_n1", tx_valid, 1'b1);
    check("t1_data_n1", tx_data, 8'h4B);
    check("t1_en_n1_old", en, 4'b0000);
    idle(1);
    check("t1_en_n2", en, exp_en);
    for (int k = 0; k < 5; k++) begin
      check("t1_hold_valid", tx_valid, 1'b1);
      check("t1_hold_data", tx_data, 8'h4B);
      idle(1);
    end
    ack("t1_ack");

    // Blink on LED2, toggle LED1 off, then watch the blink period
    frame("2", "B");
    ack("t2_blk");
    frame("1", "T");
    ack("t2_tgl");
    prev = en[2];
    for (int c = 0; c < 48; c++) begin
      @(negedge clk);
      check("t2_others_off", en & 4'b1011, 4'b0000);
      if (en[2] !== prev) edges.push_back(c);
      prev = en[2];
    end
    check("t2_blink_edges", edges.size() >= 3, 1'b1);
    for (int k = 1; k < edges.size(); k++)
      check("t2_blink_period", edges[k] - edges[k-1], 8);
    frame("2", "0");
    exp_en[2] = 1'b0;
    ack("t2_off");
    check("t2_en_after_off", en, exp_en);

    // Bad index -> 'E' with one cmd_err pulse; junk in IDLE is silent
    send("L");
    send("7");
    sb.push_back(8'h45);
    exp_err++;
    check("t3_err_pulse", cmd_err, 1'b1);
    check("t3_err_valid", tx_valid, 1'b1);
    check("t3_err_data", tx_data, 8'h45);
    idle(1);
    check("t3_err_one_cycle", cmd_err, 1'b0);
    ack("t3_ack");
    check("t3_en_kept", en, exp_en);
    send(8'h0A);
    send("x");
    idle(3);
    check("t3_idle_no_resp", tx_valid, 1'b0);

    // Timeout after 20 idle cycles
    send("L");
    send("0");
    idle(19);
    check("t4_before_timeout", tx_valid, 1'b0);
    idle(1);
    sb.push_back(8'h45);
    exp_err++;
    check("t4_timeout_valid", tx_valid, 1'b1);
    check("t4_timeout_err", cmd_err, 1'b1);
    ack("t4_ack");

    // Byte arriving exactly on the timeout cycle is accepted
    send("L");
    send("0");
    idle(18);
    send("1");
    check("t4_edge_no_err", cmd_err, 1'b0);
    check("t4_edge_no_resp", tx_valid, 1'b0);
    send(8'h0D);
    sb.push_back(8'h4B);
    exp_en[0] = 1'b1;
    ack("t4_edge_ack");
    check("t4_edge_en", en, exp_en);

    // rx during RESP: dropped with cmd_err, response untouched
    frame("0", "0");
    send("L");
    exp_err++;
    check("t5_drop_err", cmd_err, 1'b1);
    check("t5_drop_valid", tx_valid, 1'b1);
    check("t5_drop_data", tx_data, 8'h4B);
    ack("t5_ack");
    send("2");
    send("1");
    send(8'h0D);
    idle(3);
    check("t5_no_frame", tx_valid, 1'b0);
    check("t5_en", en, exp_en);

    // All on, then asynchronous reset mid-frame
    frame("0", "1"); ack("t6_a0");
    frame("1", "1"); ack("t6_a1");
    frame("2", "1"); ack("t6_a2");
    frame("3", "1"); ack("t6_a3");
    idle(1);
    check("t6_all_on", en, 4'b1111);
    send("L");
    send("3");
    n_reset = 1'b0;
    #1;
    check("t6_async_en", en, 4'b0000);
    check("t6_async_valid", tx_valid, 1'b0);
    check("t6_async_data", tx_data, 8'h00);
    @(negedge clk);
    n_reset = 1'b1;
    exp_en  = 4'b0000;
    sb.delete();
    frame("3", "1");
    ack("t6_post");
    check("t6_post_en", en, 4'b1000);

    idle(2);
    check("sb_empty", sb.size(), 0);
    check("cmd_err_count", err_seen, exp_err);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_cmd_decoder.md
Name: led_cmd_decoder

Overview:
- Sits between the UART receiver and the 4-LED driver, whose output is led = ~en.
- Parses ASCII command frames from received bytes and maintains the 4-bit en vector, with per-LED on, off, toggle and blink.
- Returns a one-byte acknowledge ('K' or 'E') to the UART transmitter over a valid/ready handshake.
- Clock domain: clk at 1 MHz.

Parameters:
- BLINK_HALF, 250000, clk cycles per blink half-period (2 Hz blink at 1 MHz); minimum 2.
- TIMEOUT_CYC, 10000, maximum clk cycles between bytes inside a frame before the frame is aborted; minimum 2.

Ports:
- clk  in  1  system clock, 1 MHz
- n_reset  in  1  asynchronous, active-low reset
- rx_data  in  8  received byte, valid only while rx_valid = 1
- rx_valid  in  1  one-cycle strobe per received byte
- tx_data  out  8  acknowledge byte
- tx_valid  out  1  acknowledge byte available
- tx_ready  in  1  transmitter accepts tx_data when tx_valid and tx_ready are both 1
- en  out  4  LED enable vector to the LED driver, registered
- cmd_err  out  1  one-cycle pulse per protocol error

Behaviour:
- Reset: reset n_reset, asynchronous, active-low; clock clk.
- Reset values:
  - state IDLE; en = 4'b0000 (all LEDs off); static_en = 0; blink_mask = 0.
  - blink_phase = 0; prescaler = 0; gap counter = 0.
  - tx_valid = 0; tx_data = 8'h00; cmd_err = 0.
- Frame format: 'L' (or 'l'), idx '0'..'3', op, terminator 0x0D or 0x0A.
  - Valid ops: '0' off, '1' on, 'T'/'t' toggle, 'B'/'b' blink.
- A byte is consumed only on a cycle where rx_valid = 1.
- FSM states: IDLE, GOT_L, GOT_IDX, GOT_OP, RESP.
  - IDLE: 'L'/'l' -> GOT_L. Any other byte is ignored silently, with no error; this tolerates stray CR/LF.
  - GOT_L: '0'..'3' -> latch idx[1:0], go to GOT_IDX. Any other byte -> error.
  - GOT_IDX: valid op -> latch op, go to GOT_OP. Any other byte -> error.
  - GOT_OP: 0x0D or 0x0A -> apply op, load tx_data = 'K' (0x4B), go to RESP. Any other byte -> error.
  - Error: load tx_data = 'E' (0x45), pulse cmd_err, go to RESP.
  - RESP: tx_valid = 1 and tx_data is held stable until tx_valid & tx_ready.
    - On that handshake cycle: tx_valid deasserts on the next edge and the FSM returns to IDLE.
    - rx_valid during RESP: byte dropped, cmd_err pulses, tx_data unchanged.
- Timeout (GOT_L, GOT_IDX, GOT_OP only):
  - The gap counter clears on every consumed byte and increments otherwise.
  - When it reaches TIMEOUT_CYC-1 with no rx_valid, the frame takes the error path.
  - rx_valid in the same cycle as the timeout takes precedence: the byte is processed normally.
- Op application, performed at the edge that consumes the terminator:
  - '0': static_en[idx] = 0, blink_mask[idx] = 0.
  - '1': static_en[idx] = 1, blink_mask[idx] = 0.
  - 'T': static_en[idx] = ~en[idx] (the currently displayed value, including blink phase), blink_mask[idx] = 0.
  - 'B': blink_mask[idx] = 1; static_en[idx] unchanged.
  - Other bits are never disturbed.
- Blink generator:
  - Free-running prescaler counts 0..BLINK_HALF-1.
  - At the wrap, blink_phase toggles.
  - Never reset by commands.
- Output register, updated every cycle: en[i] = blink_mask[i] ? blink_phase : static_en[i].
- Latency, with the terminator sampled in cycle N:
  - tx_valid = 1 from cycle N+1.
  - en reflects the new op from cycle N+2.
- cmd_err is high for exactly one cycle per error event.
- Reset asserted mid-frame or mid-RESP: everything returns to reset values immediately. Any pending acknowledge is discarded.

Decomposition:
- Shared package led_cmd_pkg holds:
  - ASCII constants: 'L', 'l', '0'-'3', 'T', 't', 'B', 'b', CR, LF, 'K', 'E'.
  - FSM state encoding.
  - 2-bit op encoding: OFF, ON, TGL, BLK.
- One sub-module: blink_gen (parameter BLINK_HALF; outputs blink_phase). It holds the prescaler and the phase flop.
- The FSM, gap counter and en logic stay in led_cmd_decoder.

Test Plan:
All scenarios use the simulation overrides BLINK_HALF=8, TIMEOUT_CYC=20.
- Reset, then send "L1" "1" 0x0D with bytes 3 cycles apart -> tx_valid with tx_data=0x4B one cycle after CR; en=4'b0010 two cycles after CR. Hold tx_ready=0 for 5 cycles -> tx_data stable; pulse tx_ready -> tx_valid drops, FSM returns to IDLE.
- From en=4'b0010, send "L2B\r", then "L1T\r" -> en[2] toggles every 8 cycles; en[1]=0; en[0]=en[3]=0 throughout.
- Send "L7" -> 'E' response and one cmd_err pulse on '7'; en unchanged. Send 0x0A, 'x' while in IDLE -> no response, no cmd_err.
- Send "L0", then idle 20 cycles -> 'E' response and cmd_err pulse. Repeat with the next byte arriving exactly on the timeout cycle -> byte accepted, no error.
- While in RESP with tx_ready=0, strobe rx_valid with 'L' -> cmd_err pulses; tx_data unchanged; no new frame started.
- Set en=4'b1111 via four frames, then assert n_reset mid-frame ("L3") -> en=0, tx_valid=0 asynchronously. After release, "L3" "1" CR -> en=4'b1000.
